// File: rtl/pim_pkg.sv
// Shared definitions for the PIM MAC sequencer: CFU op codes, FSM states and index-width helper.
package pim_pkg;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_PLOAD = 3'd2;
    localparam logic [2:0] OP_MAC   = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;

    // Bit position of the plane select inside a PLOAD operand 0.
    localparam int PLANE_SEL_LSB = 8;
    localparam int PLANE_WORD_W  = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RD_CAP,
        S_PLOAD,
        S_MAC,
        S_DRAIN,
        S_CAP,
        S_CLR,
        S_BAD,
        S_RESP
    } state_e;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pim_plane_store.sv
// Input-vector bit-plane register file: 32-bit word writes, whole-plane read, single-cycle clear.
module pim_plane_store
    import pim_pkg::*;
#(
    parameter int PDEPTH = 256,
    parameter int IBITS  = 8,
    parameter int PIDX_W = idx_w(IBITS),
    parameter int WIDX_W = idx_w(PDEPTH / PLANE_WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [PIDX_W-1:0] wr_plane,
    input  logic [WIDX_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic [PIDX_W-1:0] rd_plane,
    output logic [PDEPTH-1:0] rd_data
);

    localparam int NWORDS = PDEPTH / PLANE_WORD_W;

    logic [31:0] words [IBITS][NWORDS];

    genvar gi, gw;
    generate
        for (gi = 0; gi < IBITS; gi++) begin : g_plane
            for (gw = 0; gw < NWORDS; gw++) begin : g_word
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        words[gi][gw] <= '0;
                    end else if (clr) begin
                        words[gi][gw] <= '0;
                    end else if (wr_en && wr_plane == PIDX_W'(gi) && wr_word == WIDX_W'(gw)) begin
                        words[gi][gw] <= wr_data;
                    end
                end
            end
        end
        for (gw = 0; gw < NWORDS; gw++) begin : g_rd
            assign rd_data[gw*PLANE_WORD_W +: PLANE_WORD_W] = words[rd_plane][gw];
        end
    endgenerate

endmodule

// File: rtl/pim_mac_sequencer.sv
// CFU-side controller for the pim_model macro: turns CFU commands into row write/read,
// bit-plane load/clear and bit-serial MAC cycles, and returns q or mac_out as the response.
module pim_mac_sequencer
    import pim_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int PWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int PDEPTH = 1 << AWIDTH,
    parameter int IBITS  = 8,
    parameter int DRAIN  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_payload_function_id,
    input  logic [DWIDTH-1:0] cmd_payload_inputs_0,
    input  logic [DWIDTH-1:0] cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_payload_outputs_0,
    output logic              rsp_payload_response_ok,
    output logic [PWIDTH-1:0] pim_d,
    output logic [AWIDTH-1:0] pim_addr,
    output logic [PDEPTH-1:0] pim_rwl,
    output logic              pim_w_en,
    output logic              pim_p_en,
    input  logic [PWIDTH-1:0] pim_q,
    input  logic [DWIDTH-1:0] pim_mac_out
);

    localparam int PIDX_W = idx_w(IBITS);
    localparam int WIDX_W = idx_w(PDEPTH / PLANE_WORD_W);
    localparam int CNT_W  = idx_w(IBITS + DRAIN);

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [PWIDTH-1:0] d_reg;
    logic [PIDX_W-1:0] plane_sel_reg;
    logic [WIDX_W-1:0] word_sel_reg;
    logic [DWIDTH-1:0] result_reg;
    logic              ok_reg;

    logic              ps_wr;
    logic              ps_clr;
    logic [PDEPTH-1:0] plane_bits;
    logic [2:0]        funct3;
    logic              accept;
    logic              unused_inputs;

    assign funct3 = cmd_payload_function_id[2:0];
    assign accept = (state_reg == S_IDLE) && cmd_valid;

    // funct7 and the operand bits outside addr/plane/word fields carry no meaning here.
    assign unused_inputs = ^{cmd_payload_function_id, cmd_payload_inputs_0};

    pim_plane_store #(
        .PDEPTH (PDEPTH),
        .IBITS  (IBITS),
        .PIDX_W (PIDX_W),
        .WIDX_W (WIDX_W)
    ) u_plane_store (
        .clk      (clk),
        .reset    (reset),
        .clr      (ps_clr),
        .wr_en    (ps_wr),
        .wr_plane (plane_sel_reg),
        .wr_word  (word_sel_reg),
        .wr_data  (d_reg[31:0]),
        .rd_plane (cnt_reg[PIDX_W-1:0]),
        .rd_data  (plane_bits)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        pim_w_en   = 1'b0;
        pim_p_en   = 1'b0;
        pim_rwl    = '0;
        ps_wr      = 1'b0;
        ps_clr     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (funct3)
                        OP_WRITE: state_next = S_WRITE;
                        OP_READ:  state_next = S_READ;
                        OP_PLOAD: state_next = S_PLOAD;
                        OP_MAC:   state_next = S_MAC;
                        OP_CLR:   state_next = S_CLR;
                        default:  state_next = S_BAD;
                    endcase
                end
            end
            S_WRITE: begin
                pim_w_en   = 1'b1;
                state_next = S_RESP;
            end
            S_READ:   state_next = S_RD_CAP;
            S_RD_CAP: state_next = S_RESP;
            S_PLOAD: begin
                ps_wr      = 1'b1;
                state_next = S_RESP;
            end
            S_MAC: begin
                pim_p_en = 1'b1;
                pim_rwl  = plane_bits;
                if (cnt_reg == CNT_W'(IBITS - 1)) begin
                    state_next = (DRAIN > 0) ? S_DRAIN : S_CAP;
                end
            end
            // Planes exhausted; keep p_en high so the macro pipeline flushes into mac_out.
            S_DRAIN: begin
                pim_p_en = 1'b1;
                if (cnt_reg == CNT_W'(IBITS + DRAIN - 1)) begin
                    state_next = S_CAP;
                end
            end
            S_CAP: state_next = S_RESP;
            S_CLR: begin
                ps_clr     = 1'b1;
                state_next = S_RESP;
            end
            S_BAD: state_next = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            addr_reg      <= '0;
            d_reg         <= '0;
            plane_sel_reg <= '0;
            word_sel_reg  <= '0;
            result_reg    <= '0;
            ok_reg        <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg       <= '0;
                addr_reg      <= cmd_payload_inputs_0[AWIDTH-1:0];
                d_reg         <= cmd_payload_inputs_1;
                plane_sel_reg <= cmd_payload_inputs_0[PLANE_SEL_LSB +: PIDX_W];
                word_sel_reg  <= cmd_payload_inputs_0[WIDX_W-1:0];
                result_reg    <= '0;
                ok_reg        <= (funct3 <= OP_CLR);
            end
            if (state_reg == S_MAC || state_reg == S_DRAIN) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == S_RD_CAP) begin
                result_reg <= pim_q;
            end
            if (state_reg == S_CAP) begin
                result_reg <= pim_mac_out;
            end
        end
    end

    assign pim_addr                = addr_reg;
    assign pim_d                   = (state_reg == S_WRITE) ? d_reg : '0;
    assign rsp_payload_outputs_0   = result_reg;
    assign rsp_payload_response_ok = ok_reg;

endmodule

// File: tb/tb_pim_mac_sequencer.sv
// Directed bench for pim_mac_sequencer with a behavioural pim_model stand-in (sync read, bit-serial MAC).
module tb_pim_mac_sequencer;

    localparam int AWIDTH = 8;
    localparam int PDEPTH = 256;
    localparam int DWIDTH = 32;
    localparam int PWIDTH = 32;
    localparam int IBITS  = 8;
    localparam int DRAIN  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [9:0]        cmd_payload_function_id = '0;
    logic [DWIDTH-1:0] cmd_payload_inputs_0 = '0;
    logic [DWIDTH-1:0] cmd_payload_inputs_1 = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DWIDTH-1:0] rsp_payload_outputs_0;
    logic              rsp_payload_response_ok;
    logic [PWIDTH-1:0] pim_d;
    logic [AWIDTH-1:0] pim_addr;
    logic [PDEPTH-1:0] pim_rwl;
    logic              pim_w_en;
    logic              pim_p_en;
    logic [PWIDTH-1:0] pim_q;
    logic [DWIDTH-1:0] pim_mac_out;

    always #5 clk = ~clk;

    pim_mac_sequencer #(
        .AWIDTH (AWIDTH),
        .PWIDTH (PWIDTH),
        .DWIDTH (DWIDTH),
        .PDEPTH (PDEPTH),
        .IBITS  (IBITS),
        .DRAIN  (DRAIN)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .rsp_payload_response_ok (rsp_payload_response_ok),
        .pim_d                   (pim_d),
        .pim_addr                (pim_addr),
        .pim_rwl                 (pim_rwl),
        .pim_w_en                (pim_w_en),
        .pim_p_en                (pim_p_en),
        .pim_q                   (pim_q),
        .pim_mac_out             (pim_mac_out)
    );

    // Macro stand-in: registered row read, accumulator cleared whenever p_en is low.
    logic [31:0] mem [PDEPTH] = '{default: 32'h0};
    logic [31:0] q_m = '0;
    logic [31:0] acc_m = '0;
    logic [5:0]  shift_m = '0;

    function automatic logic [31:0] colsum(input logic [PDEPTH-1:0] rwl);
        int s = 0;
        for (int r = 0; r < PDEPTH; r++) begin
            if (rwl[r]) s += $countones(mem[r]);
        end
        return 32'(s);
    endfunction

    always @(posedge clk) begin
        if (pim_w_en) mem[pim_addr] <= pim_d;
        q_m <= mem[pim_addr];
        if (pim_p_en) begin
            acc_m   <= acc_m + (colsum(pim_rwl) << shift_m);
            shift_m <= shift_m + 6'd1;
        end else begin
            acc_m   <= '0;
            shift_m <= '0;
        end
    end

    assign pim_q       = q_m;
    assign pim_mac_out = acc_m;

    // Free-running event counters; the test takes before/after deltas.
    int n_overlap = 0;
    int n_pen = 0;
    int n_pen_rwl = 0;
    int n_act = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (pim_p_en && pim_w_en) n_overlap <= n_overlap + 1;
            if (pim_p_en) n_pen <= n_pen + 1;
            if (pim_p_en && (|pim_rwl)) n_pen_rwl <= n_pen_rwl + 1;
            if (pim_p_en || pim_w_en || (|pim_rwl)) n_act <= n_act + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] out, output logic ok,
                          output int lat);
        int w;
        @(negedge clk);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {f7, f3};
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL cmd_ready_timeout: got 0, expected 1");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        out = '0;
        ok  = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            tests++;
            fails++;
            $display("[TB] FAIL rsp_timeout: got no rsp_valid, expected one within 100 cycles");
            lat = -1;
        end else begin
            out = rsp_payload_outputs_0;
            ok  = rsp_payload_response_ok;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
        $display("[TB] op=%0d in0=0x%08h in1=0x%08h -> out=0x%08h ok=%0d lat=%0d", f3, a, b, out, ok, lat);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] exp_out;
        logic        exp_ok;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] out;
        logic        ok;
        int          lat;
        int          b_ovl, b_pen, b_pr, b_act, b_rsp;

        vecs[0]  = '{3'd0, 7'd0,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2};
        vecs[1]  = '{3'd0, 7'd0,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 2};
        vecs[2]  = '{3'd1, 7'd0,  32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b1, 3};
        vecs[3]  = '{3'd1, 7'd0,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 3};
        vecs[4]  = '{3'd2, 7'd0,  32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b1, 2};
        vecs[5]  = '{3'd2, 7'd0,  32'h0000_0100, 32'h0000_0001, 32'h0000_0000, 1'b1, 2};
        vecs[6]  = '{3'd3, 7'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0061, 1'b1, 12};
        vecs[7]  = '{3'd0, 7'd0,  32'h0000_0002, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 2};
        vecs[8]  = '{3'd2, 7'd0,  32'h0000_0200, 32'h0000_0004, 32'h0000_0000, 1'b1, 2};
        vecs[9]  = '{3'd3, 7'd0,  32'h0000_0000, 32'h0000_0000, 32'd161,       1'b1, 12};
        vecs[10] = '{3'd2, 7'd0,  32'h0000_0F08, 32'h0000_0002, 32'h0000_0000, 1'b1, 2};
        vecs[11] = '{3'd3, 7'd0,  32'h0000_0000, 32'h0000_0000, 32'd289,       1'b1, 12};
        vecs[12] = '{3'd0, 7'd0,  32'h0000_0020, 32'h0000_000F, 32'h0000_0000, 1'b1, 2};
        vecs[13] = '{3'd2, 7'd0,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 2};
        vecs[14] = '{3'd3, 7'd0,  32'h0000_0000, 32'h0000_0000, 32'd293,       1'b1, 12};
        vecs[15] = '{3'd5, 7'd0,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 2};
        vecs[16] = '{3'd7, 7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2};
        vecs[17] = '{3'd1, 7'd0,  32'h0000_0020, 32'h0000_0000, 32'h0000_000F, 1'b1, 3};
        vecs[18] = '{3'd1, 7'h55, 32'h0000_0101, 32'h0000_0000, 32'h0000_0001, 1'b1, 3};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_outputs_0", rsp_payload_outputs_0, 32'd0);
        check("rst_response_ok", {31'd0, rsp_payload_response_ok}, 32'd0);
        check("rst_pim_ctrl", {30'd0, pim_p_en, pim_w_en}, 32'd0);
        check("rst_pim_rwl", {31'd0, |pim_rwl}, 32'd0);
        check("rst_pim_addr_d", {24'd0, pim_addr} | pim_d, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            b_ovl = n_overlap;
            b_pen = n_pen;
            do_cmd(vecs[i].f3, vecs[i].f7, vecs[i].in0, vecs[i].in1, out, ok, lat);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_ok", i), {31'd0, ok}, {31'd0, vecs[i].exp_ok});
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_overlap", i), 32'(n_overlap - b_ovl), 32'd0);
            check($sformatf("vec%0d_pen_cycles", i), 32'(n_pen - b_pen),
                  (vecs[i].f3 == 3'd3) ? 32'(IBITS + DRAIN) : 32'd0);
        end

        // Response back-pressure: READ r1 with rsp_ready held low for 5 cycles
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_payload_function_id = {7'd0, 3'd1};
        cmd_payload_inputs_0 = 32'h1;
        cmd_payload_inputs_1 = 32'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("hold%0d_outputs_0", c), rsp_payload_outputs_0, 32'h1);
            check($sformatf("hold%0d_cmd_ready", c), {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("hold_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("hold_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        $display("[TB] back-pressure READ r1 done");

        // CLR then MAC: every p_en cycle must see an all-zero word-line vector
        do_cmd(3'd4, 7'd0, 32'h0, 32'h0, out, ok, lat);
        check("clr_out", out, 32'd0);
        check("clr_ok", {31'd0, ok}, 32'd1);
        b_pr  = n_pen_rwl;
        b_pen = n_pen;
        do_cmd(3'd3, 7'd0, 32'h0, 32'h0, out, ok, lat);
        check("clr_mac_out", out, 32'd0);
        check("clr_mac_rwl_active", 32'(n_pen_rwl - b_pr), 32'd0);
        check("clr_mac_pen_cycles", 32'(n_pen - b_pen), 32'(IBITS + DRAIN));

        // Reset during MAC cycle 3 (plane 2 loaded so rwl is non-zero there)
        do_cmd(3'd2, 7'd0, 32'h0000_0200, 32'h0000_0004, out, ok, lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_payload_function_id = {7'd0, 3'd3};
        cmd_payload_inputs_0 = 32'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mac_pen_before", {31'd0, pim_p_en}, 32'd1);
        check("mid_mac_rwl_before", {31'd0, |pim_rwl}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_mac_pen_after_rst", {31'd0, pim_p_en}, 32'd0);
        check("mid_mac_rwl_after_rst", {31'd0, |pim_rwl}, 32'd0);
        check("mid_mac_cmd_ready_rst", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        b_rsp = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid) b_rsp++;
        end
        check("mid_mac_no_rsp", 32'(b_rsp), 32'd0);
        $display("[TB] reset during MAC cycle 3 done");
        do_cmd(3'd1, 7'd0, 32'h0, 32'h0, out, ok, lat);
        check("post_rst_read_r0", out, 32'hFFFF_FFFF);
        do_cmd(3'd3, 7'd0, 32'h0, 32'h0, out, ok, lat);
        check("post_rst_mac_planes_cleared", out, 32'd0);

        // Illegal funct3=6: no macro activity at all
        b_act = n_act;
        do_cmd(3'd6, 7'd0, 32'h0000_00FF, 32'hDEAD_BEEF, out, ok, lat);
        check("bad6_out", out, 32'd0);
        check("bad6_ok", {31'd0, ok}, 32'd0);
        check("bad6_lat", 32'(lat), 32'd2);
        check("bad6_pim_idle", 32'(n_act - b_act), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
